memc_arb: RTL and testbench
===========================

Name: memc_arb

Overview:
Multi-channel memory controller. It arbitrates NUM_CH independent requesters onto one single-port block RAM with registered read output.
It succeeds the single-channel controller/RAM pairing, generalised in data width, address width and channel count.
It adds round-robin or fixed-priority arbitration, per-channel grant and read-valid handshakes, and a protocol-error flag.

Parameters:
DATA_WIDTH, 8, width of read/write data.
ADDR_WIDTH, 12, width of the word address; RAM depth is 2**ADDR_WIDTH.
NUM_CH, 4, number of requesting channels; legal range 2..8.
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (ch0 highest).

Ports:
clk  input  1  single clock; all logic is rising-edge.
reset  input  1  asynchronous, active-low reset.
ch_rd_enable  input  NUM_CH  per-channel read request.
ch_wr_enable  input  NUM_CH  per-channel write request.
ch_addr  input  NUM_CH*ADDR_WIDTH  flattened addresses; channel i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
ch_wr_data  input  NUM_CH*DATA_WIDTH  flattened write data, packed the same way.
ch_grant  output  NUM_CH  one-hot, one-cycle pulse: request consumed.
ch_rd_valid  output  NUM_CH  one-hot, one-cycle pulse: ch_rd_data is valid for that channel.
ch_rd_data  output  DATA_WIDTH  shared read-return data.
busy  output  1  high whenever the FSM is not in IDLE.
proto_err  output  1  sticky: a channel asserted rd and wr together.
bram_rd_enable  output  1  RAM read strobe.
bram_wr_enable  output  1  RAM write strobe.
bram_addr  output  ADDR_WIDTH  RAM address.
bram_wr_data  output  DATA_WIDTH  RAM write data.
bram_rd_data  input  DATA_WIDTH  RAM read data, valid one cycle after bram_rd_enable.

Behaviour:
- Reset (reset low, asynchronous): all outputs 0; FSM to IDLE; RR pointer = NUM_CH-1, so ch0 wins first.
- Request on channel i = ch_rd_enable[i] | ch_wr_enable[i]. The channel holds request, ch_addr and ch_wr_data stable until it sees ch_grant[i], then may drop or change them on the next cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE, any request present in cycle T: arbiter picks winner w. In T+1 (ISSUE), ch_grant[w]=1, bram_addr and bram_wr_data = channel w's values, and the matching bram_*_enable=1. All other cycles: grant and enables are 0.
- Write path: ISSUE -> IDLE. A new request is accepted in IDLE at T+2; throughput is one write per 2 cycles.
- Read path: ISSUE -> WAIT (bram_rd_data valid in T+2, captured) -> RESP. In T+3, ch_rd_valid[w]=1 and ch_rd_data holds the word; RESP -> IDLE.
- ch_rd_data holds its last value outside RESP.
- Round-robin: search starts at pointer+1 modulo NUM_CH; the pointer updates to w on each grant.
- Fixed priority: lowest-index requester wins; the pointer is unused.
- rd and wr both asserted on one channel: treated as a write, the read is dropped, proto_err set until reset.
- Requests arriving while busy are not sampled. They must stay held and are arbitrated at the next IDLE.
- Reset asserted mid-operation: the in-flight access is abandoned. No ch_rd_valid is issued, and bram enables drop immediately.
- Read and write to the same address on consecutive accesses: serialised, so a read following a write returns the new data.

Decomposition:
- Package memc_pkg:
  - state encoding (IDLE/ISSUE/WAIT/RESP, 2 bits)
  - ARB_RR=0 and ARB_FIXED=1 constants
  - a clog2-based pointer-width constant function
- Sub-module rr_arbiter:
  - inputs: request vector, pointer, mode
  - output: one-hot winner, combinational
  - instantiated once; the FSM, pointer register and datapath muxes stay in memc_arb.

Test Plan:
- Reset with all inputs idle -> all outputs 0, busy=0; first single ch2 write addr 0x010 data 0xA5 -> ch_grant=0100 and bram_wr_enable=1 at T+1, busy low at T+2.
- ch2 read addr 0x010 after that write -> ch_grant[2] at T+1, ch_rd_valid=0100 with ch_rd_data=0xA5 at T+3.
- ARB_MODE=0, all 4 channels write continuously -> grant order ch0, ch1, ch2, ch3, ch0 at 2-cycle spacing, no channel starved.
- ARB_MODE=1, ch1 and ch3 requesting together -> ch1 granted first, ch3 granted on the following access.
- ch0 asserts rd and wr together at addr 0x020 data 0x3C -> write performed, no ch_rd_valid, proto_err=1 and held until reset.
- Read issued, then reset pulsed low during WAIT -> ch_rd_valid never asserts, outputs 0 immediately, next request arbitrated from ch0.

Source files
------------

// File: rtl/memc_pkg.sv
// Shared types and constants for the multi-channel memory controller.
package memc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Width of the round-robin pointer; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/memc_arb_if.sv
// Channel-side and RAM-side bundle of the memory controller.
// slave = controller view, master = requesters plus RAM.
interface memc_arb_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_CH     = 4
);
    logic [NUM_CH-1:0]            ch_rd_enable;
    logic [NUM_CH-1:0]            ch_wr_enable;
    logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_wr_data;
    logic [NUM_CH-1:0]            ch_grant;
    logic [NUM_CH-1:0]            ch_rd_valid;
    logic [DATA_WIDTH-1:0]        ch_rd_data;
    logic                         busy;
    logic                         proto_err;
    logic                         bram_rd_enable;
    logic                         bram_wr_enable;
    logic [ADDR_WIDTH-1:0]        bram_addr;
    logic [DATA_WIDTH-1:0]        bram_wr_data;
    logic [DATA_WIDTH-1:0]        bram_rd_data;

    modport slave (
        input  ch_rd_enable, ch_wr_enable, ch_addr, ch_wr_data, bram_rd_data,
        output ch_grant, ch_rd_valid, ch_rd_data, busy, proto_err,
               bram_rd_enable, bram_wr_enable, bram_addr, bram_wr_data
    );

    modport master (
        output ch_rd_enable, ch_wr_enable, ch_addr, ch_wr_data, bram_rd_data,
        input  ch_grant, ch_rd_valid, ch_rd_data, busy, proto_err,
               bram_rd_enable, bram_wr_enable, bram_addr, bram_wr_data
    );
endinterface

// File: rtl/memc_arb_rr_arbiter.sv
// Combinational one-hot arbiter: round-robin from ptr+1, or fixed
// priority with channel 0 highest when mode is set.
module rr_arbiter
    import memc_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int PTR_W  = ptr_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    input  logic              mode,
    output logic [NUM_CH-1:0] gnt
);

    // Walk candidates in priority order; only constant bit indices are used.
    always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            for (int j = 0; j < NUM_CH; j++) begin
                if (!found && req[j] &&
                    (mode ? (j == k) : (((int'(ptr) + 1 + k) % NUM_CH) == j))) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/memc_arb.sv
// Multi-channel single-port RAM controller: arbitrates NUM_CH requesters,
// issues one RAM access at a time and returns read data per channel.
module memc_arb
    import memc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_CH     = 4,
    parameter int ARB_MODE   = ARB_RR
) (
    input  logic      clk,
    input  logic      reset,
    memc_arb_if.slave bus
);

    localparam int   PTR_W      = ptr_width(NUM_CH);
    localparam logic FIXED_MODE = (ARB_MODE == ARB_FIXED);

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [NUM_CH-1:0]     cur_q, cur_d;
    logic [NUM_CH-1:0]     grant_q, grant_d;
    logic [NUM_CH-1:0]     rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0] bram_wr_data_q, bram_wr_data_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic                  busy_q, busy_d;
    logic                  proto_err_q, proto_err_d;
    logic                  bram_rd_en_q, bram_rd_en_d;
    logic                  bram_wr_en_q, bram_wr_en_d;
    logic                  is_rd_q, is_rd_d;

    logic [NUM_CH-1:0]     req, win;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;
    logic [PTR_W-1:0]      win_idx;
    logic                  win_rd, win_wr;

    assign req = bus.ch_rd_enable | bus.ch_wr_enable;

    rr_arbiter #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_arb (
        .req  (req),
        .ptr  (ptr_q),
        .mode (FIXED_MODE),
        .gnt  (win)
    );

    // Select the winning channel's address, data and request type.
    always_comb begin
        win_addr = '0;
        win_data = '0;
        win_idx  = '0;
        win_rd   = 1'b0;
        win_wr   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (win[i]) begin
                win_addr = bus.ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_data = bus.ch_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                win_idx  = PTR_W'(i);
                win_rd   = bus.ch_rd_enable[i];
                win_wr   = bus.ch_wr_enable[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state: writes return to IDLE after ISSUE, reads go through WAIT/RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|req) state_d = ST_ISSUE;
            ST_ISSUE: state_d = is_rd_q ? ST_WAIT : ST_IDLE;
            ST_WAIT:  state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; every port is driven from a flop.
    always_comb begin
        grant_d        = '0;
        rd_valid_d     = '0;
        bram_rd_en_d   = 1'b0;
        bram_wr_en_d   = 1'b0;
        bram_addr_d    = bram_addr_q;
        bram_wr_data_d = bram_wr_data_q;
        rd_data_d      = rd_data_q;
        ptr_d          = ptr_q;
        cur_d          = cur_q;
        is_rd_d        = is_rd_q;
        proto_err_d    = proto_err_q;
        busy_d         = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d        = win;
                    cur_d          = win;
                    bram_addr_d    = win_addr;
                    bram_wr_data_d = win_data;
                    // rd+wr together counts as a write; the read is dropped
                    bram_wr_en_d   = win_wr;
                    bram_rd_en_d   = win_rd & ~win_wr;
                    is_rd_d        = win_rd & ~win_wr;
                    if (win_rd && win_wr) proto_err_d = 1'b1;
                    if (!FIXED_MODE) ptr_d = win_idx;
                end
            end
            ST_WAIT: begin
                rd_data_d  = bus.bram_rd_data;
                rd_valid_d = cur_q;
            end
            default: ;
        endcase
    end

    // Output and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q          <= PTR_W'(NUM_CH - 1);
            cur_q          <= '0;
            grant_q        <= '0;
            rd_valid_q     <= '0;
            rd_data_q      <= '0;
            bram_wr_data_q <= '0;
            bram_addr_q    <= '0;
            busy_q         <= 1'b0;
            proto_err_q    <= 1'b0;
            bram_rd_en_q   <= 1'b0;
            bram_wr_en_q   <= 1'b0;
            is_rd_q        <= 1'b0;
        end else begin
            ptr_q          <= ptr_d;
            cur_q          <= cur_d;
            grant_q        <= grant_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
            bram_wr_data_q <= bram_wr_data_d;
            bram_addr_q    <= bram_addr_d;
            busy_q         <= busy_d;
            proto_err_q    <= proto_err_d;
            bram_rd_en_q   <= bram_rd_en_d;
            bram_wr_en_q   <= bram_wr_en_d;
            is_rd_q        <= is_rd_d;
        end
    end

    assign bus.ch_grant       = grant_q;
    assign bus.ch_rd_valid    = rd_valid_q;
    assign bus.ch_rd_data     = rd_data_q;
    assign bus.busy           = busy_q;
    assign bus.proto_err      = proto_err_q;
    assign bus.bram_rd_enable = bram_rd_en_q;
    assign bus.bram_wr_enable = bram_wr_en_q;
    assign bus.bram_addr      = bram_addr_q;
    assign bus.bram_wr_data   = bram_wr_data_q;

endmodule

// File: tb/tb_memc_arb.sv
// Scoreboard bench for memc_arb: one round-robin and one fixed-priority
// instance, each backed by a behavioural single-port RAM.
module tb_memc_arb;
    import memc_pkg::*;

    localparam int DW = 8;
    localparam int AW = 12;
    localparam int NC = 4;

    typedef struct {
        int          ch;
        logic [DW-1:0] data;
    } rd_exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    memc_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC)) if_rr ();
    memc_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC)) if_fx ();

    memc_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC), .ARB_MODE(ARB_RR)) u_rr (
        .clk(clk), .reset(reset), .bus(if_rr));
    memc_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC), .ARB_MODE(ARB_FIXED)) u_fx (
        .clk(clk), .reset(reset), .bus(if_fx));

    logic [DW-1:0] ram_rr [0:(1<<AW)-1];
    logic [DW-1:0] ram_fx [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (if_rr.bram_wr_enable) ram_rr[if_rr.bram_addr] <= if_rr.bram_wr_data;
        if (if_rr.bram_rd_enable) if_rr.bram_rd_data <= ram_rr[if_rr.bram_addr];
    end

    always @(posedge clk) begin
        if (if_fx.bram_wr_enable) ram_fx[if_fx.bram_addr] <= if_fx.bram_wr_data;
        if (if_fx.bram_rd_enable) if_fx.bram_rd_data <= ram_fx[if_fx.bram_addr];
    end

    int            n_vec = 0;
    int            n_err = 0;
    int            exp_gnt[$];
    rd_exp_t       exp_rd[$];
    logic [DW-1:0] shadow [int];

    task automatic clear_reqs();
        if_rr.ch_rd_enable = '0; if_rr.ch_wr_enable = '0;
        if_rr.ch_addr      = '0; if_rr.ch_wr_data   = '0;
        if_fx.ch_rd_enable = '0; if_fx.ch_wr_enable = '0;
        if_fx.ch_addr      = '0; if_fx.ch_wr_data   = '0;
    endtask

    task automatic set_req(input bit fx, input int ch, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [1:0] c;
        c = ch[1:0];
        if (fx) begin
            if_fx.ch_rd_enable[c] = rd; if_fx.ch_wr_enable[c] = wr;
            if_fx.ch_addr[ch*AW +: AW] = a; if_fx.ch_wr_data[ch*DW +: DW] = d;
        end else begin
            if_rr.ch_rd_enable[c] = rd; if_rr.ch_wr_enable[c] = wr;
            if_rr.ch_addr[ch*AW +: AW] = a; if_rr.ch_wr_data[ch*DW +: DW] = d;
        end
    endtask

    // Bounded wait for a grant; returns 0 on timeout. cyc counts negedges.
    task automatic wait_grant(input bit fx, output logic [NC-1:0] g, output int cyc);
        g = '0; cyc = 0;
        repeat (20) begin
            @(negedge clk); cyc++;
            g = fx ? if_fx.ch_grant : if_rr.ch_grant;
            if (g != '0) break;
        end
    endtask

    task automatic wait_rdv(output logic [NC-1:0] v, output logic [DW-1:0] d, output int cyc);
        v = '0; d = '0; cyc = 0;
        repeat (20) begin
            @(negedge clk); cyc++;
            v = if_rr.ch_rd_valid; d = if_rr.ch_rd_data;
            if (v != '0) break;
        end
    endtask

    function automatic logic [NC+NC+DW+4+AW+DW-1:0] obs_rr();
        return {if_rr.ch_grant, if_rr.ch_rd_valid, if_rr.ch_rd_data, if_rr.busy, if_rr.proto_err,
                if_rr.bram_rd_enable, if_rr.bram_wr_enable, if_rr.bram_addr, if_rr.bram_wr_data};
    endfunction

    function automatic logic [NC+NC+DW+4+AW+DW-1:0] obs_fx();
        return {if_fx.ch_grant, if_fx.ch_rd_valid, if_fx.ch_rd_data, if_fx.busy, if_fx.proto_err,
                if_fx.bram_rd_enable, if_fx.bram_wr_enable, if_fx.bram_addr, if_fx.bram_wr_data};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        clear_reqs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (obs_rr() !== '0) begin n_err++;
            $display("FAIL reset_rr outputs got %h want 0", obs_rr()); end
        n_vec++; if (obs_fx() !== '0) begin n_err++;
            $display("FAIL reset_fx outputs got %h want 0", obs_fx()); end
        reset = 1'b1;
        @(negedge clk);
        n_vec++; if (if_rr.busy !== 1'b0) begin n_err++;
            $display("FAIL idle_busy got %b want 0", if_rr.busy); end
    endtask

    task automatic test_write();
        logic [NC-1:0] g; int cyc; int e;
        @(posedge clk); #1;
        set_req(0, 2, 0, 1, 12'h010, 8'hA5);
        shadow[12'h010] = 8'hA5;
        exp_gnt.push_back(2);
        wait_grant(0, g, cyc);
        e = exp_gnt.pop_front();
        n_vec++; if (g !== (NC'(1) << e) || cyc != 2) begin n_err++;
            $display("FAIL wr_grant got %b@%0d want %b@2", g, cyc, NC'(1) << e); end
        n_vec++; if ({if_rr.bram_wr_enable, if_rr.bram_rd_enable, if_rr.bram_addr, if_rr.bram_wr_data}
                     !== {2'b10, 12'h010, 8'hA5}) begin n_err++;
            $display("FAIL wr_bram got we=%b re=%b a=%h d=%h want we=1 re=0 a=010 d=a5",
                     if_rr.bram_wr_enable, if_rr.bram_rd_enable, if_rr.bram_addr, if_rr.bram_wr_data); end
        clear_reqs();
        @(negedge clk);
        n_vec++; if (if_rr.busy !== 1'b0 || if_rr.bram_wr_enable !== 1'b0) begin n_err++;
            $display("FAIL wr_done busy=%b we=%b want 0 0", if_rr.busy, if_rr.bram_wr_enable); end
    endtask

    task automatic test_read();
        logic [NC-1:0] g, v; logic [DW-1:0] d; int cyc; int e; rd_exp_t r;
        @(posedge clk); #1;
        set_req(0, 2, 1, 0, 12'h010, 8'h00);
        exp_gnt.push_back(2);
        exp_rd.push_back('{ch: 2, data: shadow[12'h010]});
        wait_grant(0, g, cyc);
        e = exp_gnt.pop_front();
        n_vec++; if (g !== (NC'(1) << e) || cyc != 2 || if_rr.bram_rd_enable !== 1'b1) begin n_err++;
            $display("FAIL rd_grant got %b@%0d re=%b want %b@2 re=1", g, cyc, if_rr.bram_rd_enable, NC'(1) << e); end
        clear_reqs();
        wait_rdv(v, d, cyc);
        r = exp_rd.pop_front();
        n_vec++; if (v !== (NC'(1) << r.ch) || d !== r.data || cyc != 2) begin n_err++;
            $display("FAIL rd_resp got v=%b d=%h@%0d want v=%b d=%h@2", v, d, cyc, NC'(1) << r.ch, r.data); end
        @(negedge clk);
        n_vec++; if (if_rr.ch_rd_valid !== '0 || if_rr.ch_rd_data !== r.data) begin n_err++;
            $display("FAIL rd_hold got v=%b d=%h want v=0 d=%h", if_rr.ch_rd_valid, if_rr.ch_rd_data, r.data); end
    endtask

    // Write then immediately read the same address from another channel.
    task automatic test_back_to_back();
        logic [NC-1:0] g, v; logic [DW-1:0] d; int cyc; int e; rd_exp_t r;
        @(posedge clk); #1;
        set_req(0, 1, 0, 1, 12'h200, 8'h5A);
        shadow[12'h200] = 8'h5A;
        exp_gnt.push_back(1);
        wait_grant(0, g, cyc);
        e = exp_gnt.pop_front();
        n_vec++; if (g !== (NC'(1) << e)) begin n_err++;
            $display("FAIL b2b_wr_grant got %b want %b", g, NC'(1) << e); end
        clear_reqs();
        set_req(0, 3, 1, 0, 12'h200, 8'h00);
        exp_gnt.push_back(3);
        exp_rd.push_back('{ch: 3, data: shadow[12'h200]});
        wait_grant(0, g, cyc);
        e = exp_gnt.pop_front();
        n_vec++; if (g !== (NC'(1) << e) || cyc != 2) begin n_err++;
            $display("FAIL b2b_rd_grant got %b@%0d want %b@2", g, cyc, NC'(1) << e); end
        clear_reqs();
        wait_rdv(v, d, cyc);
        r = exp_rd.pop_front();
        n_vec++; if (v !== (NC'(1) << r.ch) || d !== r.data) begin n_err++;
            $display("FAIL b2b_rd_data got v=%b d=%h want v=%b d=%h", v, d, NC'(1) << r.ch, r.data); end
    endtask

    task automatic test_rr_fair();
        logic [NC-1:0] g; int cyc; int e;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NC; i++) begin
            set_req(0, i, 0, 1, AW'(12'h100 + i), DW'(8'h40 + i));
            shadow[12'h100 + i] = DW'(8'h40 + i);
        end
        for (int k = 0; k < 2 * NC; k++) exp_gnt.push_back(k % NC);
        for (int k = 0; k < 2 * NC; k++) begin
            wait_grant(0, g, cyc);
            e = exp_gnt.pop_front();
            n_vec++; if (g !== (NC'(1) << e) || cyc != 2) begin n_err++;
                $display("FAIL rr_order[%0d] got %b@%0d want %b@2", k, g, cyc, NC'(1) << e); end
        end
        clear_reqs();
        repeat (2) @(negedge clk);
    endtask

    // ch2 first moves a round-robin pointer to 2, so only fixed priority picks ch1 next.
    task automatic test_fixed();
        logic [NC-1:0] g; int cyc; int e;
        @(posedge clk); #1;
        set_req(1, 2, 0, 1, 12'h300, 8'h11);
        exp_gnt.push_back(2);
        wait_grant(1, g, cyc);
        e = exp_gnt.pop_front();
        n_vec++; if (g !== (NC'(1) << e)) begin n_err++;
            $display("FAIL fx_first got %b want %b", g, NC'(1) << e); end
        clear_reqs();
        set_req(1, 1, 0, 1, 12'h301, 8'h22);
        set_req(1, 3, 0, 1, 12'h303, 8'h33);
        exp_gnt.push_back(1);
        exp_gnt.push_back(3);
        wait_grant(1, g, cyc);
        e = exp_gnt.pop_front();
        n_vec++; if (g !== (NC'(1) << e)) begin n_err++;
            $display("FAIL fx_prio got %b want %b", g, NC'(1) << e); end
        set_req(1, 1, 0, 0, 12'h000, 8'h00);
        wait_grant(1, g, cyc);
        e = exp_gnt.pop_front();
        n_vec++; if (g !== (NC'(1) << e) || cyc != 2) begin n_err++;
            $display("FAIL fx_next got %b@%0d want %b@2", g, cyc, NC'(1) << e); end
        clear_reqs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_proto();
        logic [NC-1:0] g, v; logic [DW-1:0] d; int cyc; int e; int seen; rd_exp_t r;
        @(posedge clk); #1;
        set_req(0, 0, 1, 1, 12'h020, 8'h3C);
        shadow[12'h020] = 8'h3C;
        exp_gnt.push_back(0);
        wait_grant(0, g, cyc);
        e = exp_gnt.pop_front();
        n_vec++; if (g !== (NC'(1) << e) || {if_rr.bram_wr_enable, if_rr.bram_rd_enable, if_rr.proto_err} !== 3'b101)
            begin n_err++;
            $display("FAIL proto_issue got g=%b we=%b re=%b pe=%b want g=%b we=1 re=0 pe=1",
                     g, if_rr.bram_wr_enable, if_rr.bram_rd_enable, if_rr.proto_err, NC'(1) << e); end
        clear_reqs();
        seen = 0;
        repeat (6) begin @(negedge clk); if (if_rr.ch_rd_valid != '0) seen++; end
        n_vec++; if (seen != 0 || if_rr.proto_err !== 1'b1) begin n_err++;
            $display("FAIL proto_norv got rdv_count=%0d pe=%b want 0 1", seen, if_rr.proto_err); end
        @(posedge clk); #1;
        set_req(0, 0, 1, 0, 12'h020, 8'h00);
        exp_rd.push_back('{ch: 0, data: shadow[12'h020]});
        wait_grant(0, g, cyc);
        clear_reqs();
        wait_rdv(v, d, cyc);
        r = exp_rd.pop_front();
        n_vec++; if (v !== (NC'(1) << r.ch) || d !== r.data || if_rr.proto_err !== 1'b1) begin n_err++;
            $display("FAIL proto_readback got v=%b d=%h pe=%b want v=%b d=%h pe=1",
                     v, d, if_rr.proto_err, NC'(1) << r.ch, r.data); end
    endtask

    task automatic test_reset_mid();
        logic [NC-1:0] g; int cyc; int seen;
        @(posedge clk); #1;
        set_req(0, 1, 1, 0, 12'h010, 8'h00);
        wait_grant(0, g, cyc);
        n_vec++; if (g !== 4'b0010) begin n_err++;
            $display("FAIL rstmid_grant got %b want 0010", g); end
        clear_reqs();
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        n_vec++; if (obs_rr() !== '0) begin n_err++;
            $display("FAIL rstmid_outputs got %h want 0", obs_rr()); end
        @(negedge clk); reset = 1'b1;
        seen = 0;
        repeat (5) begin @(negedge clk); if (if_rr.ch_rd_valid != '0) seen++; end
        n_vec++; if (seen != 0) begin n_err++;
            $display("FAIL rstmid_norv got rdv_count=%0d want 0", seen); end
        @(posedge clk); #1;
        set_req(0, 0, 0, 1, 12'h400, 8'h01);
        set_req(0, 3, 0, 1, 12'h403, 8'h03);
        exp_gnt.push_back(0);
        wait_grant(0, g, cyc);
        n_vec++; if (g !== (NC'(1) << exp_gnt.pop_front())) begin n_err++;
            $display("FAIL rstmid_ptr got %b want 0001", g); end
        clear_reqs();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_reqs();
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_rr_fair();
        test_fixed();
        test_proto();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
